dual_boot_ctrl: RTL and testbench



---
 rtl/dual_boot_ctrl_pkg.sv | 33 +++
 rtl/key_debounce.sv | 61 ++++++
 rtl/dual_boot_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_dual_boot_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dual_boot_ctrl_pkg.sv
// Shared constants for the dual-boot reconfiguration controller: the remote-update
// register map, the bit positions inside those registers, and the sequencer states.
package dual_boot_ctrl_pkg;

  localparam logic [2:0] REG_TRIGGER = 3'd0;
  localparam logic [2:0] REG_CONFIG  = 3'd1;
  localparam logic [2:0] REG_STATUS  = 3'd3;

  localparam int BUSY_BIT = 0;
  localparam int OVR_BIT  = 0;
  localparam int SEL_BIT  = 1;

  localparam logic [31:0] TRIGGER_WORD = 32'h0000_0001;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_POLL_RD   = 3'd1,
    ST_POLL_WAIT = 3'd2,
    ST_SEL_WR    = 3'd3,
    ST_TRIG_WR   = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  // Config register word: force the image choice and select the requested image.
  function automatic logic [31:0] config_word(input logic sel);
    logic [31:0] word;
    word          = 32'h0000_0000;
    word[OVR_BIT] = 1'b1;
    word[SEL_BIT] = sel;
    return word;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push button: two-flop synchronizer, stability counter and a single-cycle
// press event on the debounced falling edge (keys are active-low).
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta_r;
  logic             sync_r;
  logic             level_r;
  logic             stable_r;
  logic [CNT_W-1:0] cnt_r;
  logic             press_r;

  logic             stable_next_s;
  logic [CNT_W-1:0] cnt_next_s;
  logic             press_next_s;

  // Stability counter: restart on any level change, commit the level once it has held.
  always_comb begin
    cnt_next_s    = cnt_r;
    stable_next_s = stable_r;
    if (sync_r != level_r) begin
      cnt_next_s = {CNT_W{1'b0}};
    end else if (cnt_r == CNT_LAST) begin
      stable_next_s = level_r;
    end else begin
      cnt_next_s = cnt_r + CNT_W'(1);
    end
    press_next_s = stable_r & ~stable_next_s;
  end

  // Synchronizer, debounce and event registers; released level is 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta_r <= 1'b1;
      sync_r      <= 1'b1;
      level_r     <= 1'b1;
      stable_r    <= 1'b1;
      cnt_r       <= {CNT_W{1'b0}};
      press_r     <= 1'b0;
    end else begin
      sync_meta_r <= key_n;
      sync_r      <= sync_meta_r;
      level_r     <= sync_r;
      stable_r    <= stable_next_s;
      cnt_r       <= cnt_next_s;
      press_r     <= press_next_s;
    end
  end

  assign press = press_r;

endmodule

// File: rtl/dual_boot_ctrl.sv
// Key-driven sequencer for the MAX 10 dual-boot IP: waits for the IP to go idle,
// programs the image select, fires the reconfiguration trigger and reports status.
module dual_boot_ctrl
  import dual_boot_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int POLL_TIMEOUT    = 65535
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  key_n,
  output logic [2:0]  avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        error,
  output logic        image_sel,
  output logic        done
);

  localparam int POLL_W = (POLL_TIMEOUT > 1) ? $clog2(POLL_TIMEOUT) : 1;
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_TIMEOUT - 1);

  logic        press0_s;
  logic        press1_s;
  logic        unused_s;

  state_t      state_r;
  state_t      state_next_s;
  logic [POLL_W-1:0] poll_cnt_r;
  logic [POLL_W-1:0] poll_next_s;
  logic        image_sel_r;
  logic        img_next_s;
  logic        error_r;
  logic        err_next_s;

  logic [2:0]  avm_address_r;
  logic        avm_read_r;
  logic        avm_write_r;
  logic [31:0] avm_writedata_r;
  logic        busy_r;
  logic        done_r;

  logic [2:0]  addr_next_s;
  logic        rd_next_s;
  logic        wr_next_s;
  logic [31:0] wdata_next_s;
  logic        busy_next_s;
  logic        done_next_s;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key0 (
    .clk     (clk),
    .reset_n (reset_n),
    .key_n   (key_n[0]),
    .press   (press0_s)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1 (
    .clk     (clk),
    .reset_n (reset_n),
    .key_n   (key_n[1]),
    .press   (press1_s)
  );

  // Only the busy flag of the status word matters to the sequencer.
  assign unused_s = ^avm_readdata[31:1];

  // Sequencer next state plus the request bookkeeping it owns.
  always_comb begin
    state_next_s = state_r;
    poll_next_s  = poll_cnt_r;
    img_next_s   = image_sel_r;
    err_next_s   = error_r;
    case (state_r)
      ST_IDLE: begin
        if (press0_s || press1_s) begin
          state_next_s = ST_POLL_RD;
          img_next_s   = press0_s ? 1'b0 : 1'b1;
          err_next_s   = 1'b0;
          poll_next_s  = {POLL_W{1'b0}};
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_POLL_RD: begin
        if (!avm_waitrequest) begin
          state_next_s = ST_POLL_WAIT;
        end else begin
          state_next_s = ST_POLL_RD;
        end
      end
      ST_POLL_WAIT: begin
        if (avm_readdatavalid) begin
          if (!avm_readdata[BUSY_BIT]) begin
            state_next_s = ST_SEL_WR;
          end else if (poll_cnt_r == POLL_LAST) begin
            err_next_s   = 1'b1;
            state_next_s = ST_IDLE;
          end else begin
            poll_next_s  = poll_cnt_r + POLL_W'(1);
            state_next_s = ST_POLL_RD;
          end
        end else begin
          state_next_s = ST_POLL_WAIT;
        end
      end
      ST_SEL_WR: begin
        if (!avm_waitrequest) begin
          state_next_s = ST_TRIG_WR;
        end else begin
          state_next_s = ST_SEL_WR;
        end
      end
      ST_TRIG_WR: begin
        if (!avm_waitrequest) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_TRIG_WR;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Bus and status values for the state being entered, so outputs are registered.
  always_comb begin
    rd_next_s    = 1'b0;
    wr_next_s    = 1'b0;
    addr_next_s  = 3'd0;
    wdata_next_s = 32'h0000_0000;
    case (state_next_s)
      ST_POLL_RD: begin
        rd_next_s   = 1'b1;
        addr_next_s = REG_STATUS;
      end
      ST_SEL_WR: begin
        wr_next_s    = 1'b1;
        addr_next_s  = REG_CONFIG;
        wdata_next_s = config_word(img_next_s);
      end
      ST_TRIG_WR: begin
        wr_next_s    = 1'b1;
        addr_next_s  = REG_TRIGGER;
        wdata_next_s = TRIGGER_WORD;
      end
      default: begin
        rd_next_s = 1'b0;
      end
    endcase
    busy_next_s = (state_next_s != ST_IDLE);
    done_next_s = (state_next_s == ST_DONE);
  end

  // State and output registers; reset drops any transfer in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r         <= ST_IDLE;
      poll_cnt_r      <= {POLL_W{1'b0}};
      image_sel_r     <= 1'b0;
      error_r         <= 1'b0;
      avm_address_r   <= 3'd0;
      avm_read_r      <= 1'b0;
      avm_write_r     <= 1'b0;
      avm_writedata_r <= 32'h0000_0000;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
    end else begin
      state_r         <= state_next_s;
      poll_cnt_r      <= poll_next_s;
      image_sel_r     <= img_next_s;
      error_r         <= err_next_s;
      avm_address_r   <= addr_next_s;
      avm_read_r      <= rd_next_s;
      avm_write_r     <= wr_next_s;
      avm_writedata_r <= wdata_next_s;
      busy_r          <= busy_next_s;
      done_r          <= done_next_s;
    end
  end

  assign avm_address   = avm_address_r;
  assign avm_read      = avm_read_r;
  assign avm_write     = avm_write_r;
  assign avm_writedata = avm_writedata_r;
  assign busy          = busy_r;
  assign error         = error_r;
  assign image_sel     = image_sel_r;
  assign done          = done_r;

endmodule

// File: tb/tb_dual_boot_ctrl.sv
// Scoreboard bench for dual_boot_ctrl: a behavioural request model queues expected
// bus transfers and done pulses; a monitor pops them as the DUT produces them.
module tb_dual_boot_ctrl;

  localparam int DEB = 8;
  localparam int PTO = 4;

  localparam logic [1:0] K_READ  = 2'd0;
  localparam logic [1:0] K_WRITE = 2'd1;
  localparam logic [1:0] K_DONE  = 2'd2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  key_n = 2'b11;
  logic [2:0]  avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = 32'h0;
  logic        avm_readdatavalid = 1'b0;
  logic        avm_waitrequest = 1'b0;
  logic        busy;
  logic        error;
  logic        image_sel;
  logic        done;

  int errors = 0;
  int checks = 0;

  // slave behaviour knobs
  int wait_states = 0;
  bit rand_wait = 1'b0;
  int extra_lat_max = 0;
  int busy_left = 0;
  int hold_checks = 0;

  logic [36:0] exp_q[$];

  always #5 clk = ~clk;

  dual_boot_ctrl #(.DEBOUNCE_CYCLES(DEB), .POLL_TIMEOUT(PTO)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .key_n             (key_n),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_waitrequest   (avm_waitrequest),
    .busy              (busy),
    .error             (error),
    .image_sel         (image_sel),
    .done              (done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Reference model: a request polls until the IP is free (or gives up after
  // PTO busy reads), then writes the config word and the trigger.
  task automatic expect_request(input logic img, input int busy_reads);
    int nreads;
    nreads = (busy_reads >= PTO) ? PTO : busy_reads + 1;
    for (int i = 0; i < nreads; i++) exp_q.push_back({K_READ, 3'd3, 32'h0});
    if (busy_reads < PTO) begin
      exp_q.push_back({K_WRITE, 3'd1, 32'(2 * img + 1)});
      exp_q.push_back({K_WRITE, 3'd0, 32'h1});
      exp_q.push_back({K_DONE, 3'd0, 32'h0});
    end
  endtask

  task automatic got_txn(input logic [36:0] t);
    logic [36:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_txn: got 0x%0h expected none", t);
    end else begin
      e = exp_q.pop_front();
      check("txn", 64'(t), 64'(e));
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_complete"}, 64'(n < budget), 64'd1);
  endtask

  // Monitor: transfers, done pulses and bus-protocol rules, sampled mid-cycle.
  initial begin : monitor
    bit          hold_valid;
    logic [1:0]  hold_strb;
    logic [2:0]  hold_addr;
    logic [31:0] hold_data;
    hold_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (avm_read || avm_write) check("rd_wr_exclusive", 64'(avm_read & avm_write), 64'd0);
        if (hold_valid) begin
          hold_checks++;
          check("hold_strobe", 64'({avm_read, avm_write}), 64'(hold_strb));
          check("hold_addr", 64'(avm_address), 64'(hold_addr));
          if (avm_write) check("hold_data", 64'(avm_writedata), 64'(hold_data));
        end
        hold_valid = (avm_read || avm_write) && avm_waitrequest;
        hold_strb  = {avm_read, avm_write};
        hold_addr  = avm_address;
        hold_data  = avm_writedata;
        if ((avm_read || avm_write) && !avm_waitrequest)
          got_txn({avm_write ? K_WRITE : K_READ, avm_address, avm_write ? avm_writedata : 32'h0});
        if (done) got_txn({K_DONE, 3'd0, 32'h0});
      end else begin
        hold_valid = 1'b0;
      end
    end
  end

  // Avalon slave model: wait states per transfer, status read data with latency.
  initial begin : slave
    bit          fire;
    bit          rd_fire;
    bit          active;
    bit          pend;
    int          wcnt;
    int          cur_wait;
    int          lat;
    logic [31:0] rdata;
    active = 1'b0; pend = 1'b0; wcnt = 0; cur_wait = 0; lat = 0;
    forever begin
      @(negedge clk);
      fire    = reset_n && (avm_read || avm_write) && !avm_waitrequest;
      rd_fire = fire && avm_read;
      @(posedge clk);
      #1;
      if (!reset_n) begin
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        active = 1'b0; pend = 1'b0; wcnt = 0;
      end else begin
        if (rd_fire) begin
          pend = 1'b1;
          lat  = $urandom_range(extra_lat_max, 0);
        end
        if (fire) active = 1'b0;
        avm_readdatavalid = 1'b0;
        if (pend) begin
          if (lat == 0) begin
            rdata = $urandom;
            rdata[0] = (busy_left > 0);
            if (busy_left > 0) busy_left--;
            avm_readdata      = rdata;
            avm_readdatavalid = 1'b1;
            pend = 1'b0;
          end else begin
            lat--;
          end
        end
        if (avm_read || avm_write) begin
          if (!active) begin
            active   = 1'b1;
            wcnt     = 0;
            cur_wait = rand_wait ? $urandom_range(3, 0) : wait_states;
          end
          if (wcnt < cur_wait) begin
            avm_waitrequest = 1'b1;
            wcnt++;
          end else begin
            avm_waitrequest = 1'b0;
          end
        end else begin
          avm_waitrequest = 1'b0;
          active = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    int act;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          64'({avm_read, avm_write, avm_address, avm_writedata, busy, error, image_sel, done}),
          64'd0);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);

    // 1: clean key 1 press, never busy, zero wait: minimum 5-cycle request
    wait_states = 0; rand_wait = 1'b0; extra_lat_max = 0; busy_left = 0;
    expect_request(1'b1, 0);
    key_n[1] = 1'b0;
    n = 0;
    while (!busy && n < 40) begin @(negedge clk); n++; end
    check("t1_start", 64'(n < 40), 64'd1);
    n = 0;
    while (busy && n < 50) begin @(negedge clk); n++; end
    check("t1_busy_cycles", 64'(n), 64'd5);
    check("t1_queue_empty", 64'(exp_q.size()), 64'd0);
    check("t1_image_sel", 64'(image_sel), 64'd1);
    check("t1_error", 64'(error), 64'd0);
    key_n[1] = 1'b1;
    repeat (20) @(negedge clk);

    // 2: bouncing key 0, random wait states and read latency
    rand_wait = 1'b1; extra_lat_max = 2; busy_left = $urandom_range(2, 0);
    expect_request(1'b0, busy_left);
    for (int i = 0; i < 10; i++) begin
      key_n[0] = ~key_n[0];
      repeat (3) @(negedge clk);
    end
    key_n[0] = 1'b0;
    repeat (20) @(negedge clk);
    key_n[0] = 1'b1;
    wait_idle("t2", 300);
    repeat (30) @(negedge clk);
    check("t2_queue_empty", 64'(exp_q.size()), 64'd0);
    check("t2_image_sel", 64'(image_sel), 64'd0);

    // 3: status stuck busy -> timeout, then a fresh press clears error
    rand_wait = 1'b0; wait_states = 0; extra_lat_max = 1; busy_left = 1000;
    expect_request(1'b1, 1000);
    key_n[1] = 1'b0;
    repeat (16) @(negedge clk);
    key_n[1] = 1'b1;
    wait_idle("t3", 200);
    repeat (20) @(negedge clk);
    check("t3_error_set", 64'(error), 64'd1);
    check("t3_idle", 64'(busy), 64'd0);
    busy_left = 2;
    expect_request(1'b0, 2);
    key_n[0] = 1'b0;
    n = 0;
    while (!busy && n < 40) begin @(negedge clk); n++; end
    check("t3_error_cleared", 64'(error), 64'd0);
    wait_idle("t3b", 200);
    key_n[0] = 1'b1;
    repeat (20) @(negedge clk);
    check("t3_error_after", 64'(error), 64'd0);

    // 4: five wait states on every transfer
    wait_states = 5; busy_left = 1; extra_lat_max = 1;
    hold_checks = 0;
    expect_request(1'b1, 1);
    key_n[1] = 1'b0;
    repeat (16) @(negedge clk);
    key_n[1] = 1'b1;
    wait_idle("t4", 400);
    check("t4_holds_seen", 64'(hold_checks >= 20), 64'd1);
    check("t4_image_sel", 64'(image_sel), 64'd1);
    repeat (20) @(negedge clk);

    // 5: both keys together -> image 0; key 1 while busy is ignored
    wait_states = 6; busy_left = 3; extra_lat_max = 0;
    expect_request(1'b0, 3);
    key_n = 2'b00;
    repeat (12) @(negedge clk);
    key_n = 2'b11;
    repeat (14) @(negedge clk);
    check("t5_busy_before_key1", 64'(busy), 64'd1);
    key_n[1] = 1'b0;
    repeat (14) @(negedge clk);
    check("t5_busy_during_key1", 64'(busy), 64'd1);
    key_n[1] = 1'b1;
    wait_idle("t5", 600);
    repeat (30) @(negedge clk);
    check("t5_queue_empty", 64'(exp_q.size()), 64'd0);
    check("t5_image_sel", 64'(image_sel), 64'd0);

    // 6: reset during the config write
    wait_states = 5; busy_left = 0; extra_lat_max = 0;
    expect_request(1'b1, 0);
    key_n[1] = 1'b0;
    n = 0;
    while (!(avm_write && avm_address == 3'd1) && n < 100) begin @(negedge clk); n++; end
    check("t6_reach_sel_wr", 64'(n < 100), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_reset_outputs",
          64'({avm_read, avm_write, avm_address, avm_writedata, busy, error, image_sel, done}),
          64'd0);
    exp_q.delete();
    key_n = 2'b11;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    act = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (avm_read || avm_write || busy) act++;
    end
    check("t6_no_activity", 64'(act), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
